// File: rtl/rv32i_types.sv
// Shared types for the cacheline memory path: grant owner encoding,
// arbiter FSM states and line-alignment helper.
package rv32i_types;

  // Byte offset bits inside one 256-bit (32-byte) cacheline.
  localparam int LINE_OFFSET_BITS = 5;

  // Which requester currently owns the shared memory port.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_P    = 2'd3
  } arb_owner_t;

  // Arbiter FSM: IDLE picks a winner, ISSUE holds it until the adaptor answers.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_t;

  // Clear the line-offset bits so the adaptor always sees a line address.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    line_align = {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/arb_prio_select.sv
// Fixed-priority selector D > I > P, with I promoted above D when the
// starvation override is raised.
module arb_prio_select
  import rv32i_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       p_req,
  input  logic       i_override,
  output arb_owner_t owner
);

  // Pick the single winner among the requests present this cycle.
  always_comb begin
    owner = OWN_NONE;
    if (i_req && i_override) begin
      owner = OWN_I;
    end else if (d_req) begin
      owner = OWN_D;
    end else if (i_req) begin
      owner = OWN_I;
    end else if (p_req) begin
      owner = OWN_P;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the cacheline adaptor port between i-cache, d-cache and the
// next-line prefetcher, one full line transaction at a time.
//
// Handshake: a requester raises its *_read/*_write level with a stable
// address (and d_wdata for writes); the arbiter samples requests only in
// IDLE, issues the latched transaction from the next cycle and keeps
// mem_read/mem_write/mem_addr/mem_wdata constant until mem_resp. The
// owner's *_resp pulses in the mem_resp cycle itself and *_rdata is valid
// in that cycle only. I and D hold their level until *_resp; P may drop
// its level before it is granted.
module mem_req_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  // instruction cache
  input  logic [31:0]      i_addr,
  input  logic             i_read,
  output logic [255:0]     i_rdata,
  output logic             i_resp,
  // data cache
  input  logic [31:0]      d_addr,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [255:0]     d_wdata,
  output logic [255:0]     d_rdata,
  output logic             d_resp,
  // prefetcher
  input  logic [31:0]      p_addr,
  input  logic             p_read,
  output logic [255:0]     p_rdata,
  output logic             p_resp,
  // cacheline adaptor
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [255:0]     mem_wdata,
  input  logic [255:0]     mem_rdata,
  input  logic             mem_resp,
  // grant and debug visibility
  output logic [1:0]       owner,
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q;
  arb_owner_t       sel_owner;
  logic             rd_q, wr_q;
  logic [31:0]      addr_q;
  logic [255:0]     wdata_q;
  logic [CNT_W-1:0] starve_q;

  logic grant;
  logic done;
  logic merge_hit;
  logic i_override;

  assign i_override = (starve_q == STARVE_MAX) && i_read;

  arb_prio_select u_sel (
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .p_req      (p_read),
    .i_override (i_override),
    .owner      (sel_owner)
  );

  assign grant = (state_q == ARB_IDLE) && (sel_owner != OWN_NONE);
  assign done  = (state_q == ARB_ISSUE) && mem_resp;

  // A granted prefetch for the very line the i-cache now wants serves both.
  assign merge_hit = (owner_q == OWN_P) && i_read && (line_align(i_addr) == addr_q);

  // Next-state logic: grant moves to ISSUE, adaptor completion back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (grant) state_d = ARB_ISSUE;
      ARB_ISSUE: if (mem_resp) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning transaction on grant; release ownership on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= sel_owner;
      rd_q    <= !((sel_owner == OWN_D) && d_write);
      wr_q    <= (sel_owner == OWN_D) && d_write;
      case (sel_owner)
        OWN_I:   addr_q <= line_align(i_addr);
        OWN_D:   addr_q <= line_align(d_addr);
        default: addr_q <= line_align(p_addr);
      endcase
      wdata_q <= ((sel_owner == OWN_D) && d_write) ? d_wdata : '0;
    end else if (done) begin
      owner_q <= OWN_NONE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  // Count D wins that bypassed a waiting I; an I win resets the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (grant && (sel_owner == OWN_I)) begin
      starve_q <= '0;
    end else if (grant && (sel_owner == OWN_D) && i_read && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Adaptor side is driven purely from the latched transaction.
  always_comb begin
    mem_read  = (state_q == ARB_ISSUE) && rd_q;
    mem_write = (state_q == ARB_ISSUE) && wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

  // Completion pulses and read data fan-out to the requesters.
  always_comb begin
    i_resp  = done && ((owner_q == OWN_I) || merge_hit);
    d_resp  = done && (owner_q == OWN_D);
    p_resp  = done && (owner_q == OWN_P);
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
    p_rdata = mem_rdata;
  end

  assign owner          = owner_q;
  assign dbg_state      = (state_q == ARB_ISSUE);
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: vector table plus hand-written multi-cycle
// sequences, with an expected-transaction queue checked at each issue.
module tb_mem_req_arbiter;

  localparam int W = 2 + 1 + 1 + 32 + 256;
  localparam logic [255:0] PAT_A = {8{32'hA5A5_5A5A}};
  localparam logic [255:0] PAT_B = {8{32'h0123_4567}};

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr, p_addr, mem_addr;
  logic         i_read, d_read, d_write, p_read;
  logic [255:0] d_wdata, i_rdata, d_rdata, p_rdata, mem_wdata, mem_rdata;
  logic         i_resp, d_resp, p_resp, mem_read, mem_write, mem_resp;
  logic [1:0]   owner;
  logic         dbg_state;
  logic [2:0]   dbg_starve_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         i_rd;
    logic [31:0]  i_a;
    logic         d_rd;
    logic         d_wr;
    logic [31:0]  d_a;
    logic [255:0] d_wd;
    logic         p_rd;
    logic [31:0]  p_a;
    logic [1:0]   e_own;
    logic         e_rd;
    logic         e_wr;
    logic [31:0]  e_addr;
    logic [255:0] e_wd;
    logic [2:0]   e_resp;   // {i, d, p}
    int           lat;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .p_addr(p_addr), .p_read(p_read), .p_rdata(p_rdata), .p_resp(p_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .owner(owner), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; p_read = 1'b0;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // scoreboard
  task automatic sb_push(input logic [1:0] o, input logic r, input logic w,
                         input logic [31:0] a, input logic [255:0] wd);
    exp_q.push_back({o, r, w, a, wd});
  endtask

  task automatic sb_pop_check(input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {owner, mem_read, mem_write, mem_addr, (mem_write ? mem_wdata : 256'd0)};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected issue %0h with empty queue", name, act);
    end else begin
      exp = exp_q.pop_front();
      check(name, act, exp);
    end
  endtask

  task automatic wait_issue(input string name);
    for (int c = 0; c < 30; c++) begin
      if (mem_read || mem_write) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s: no memory issue within 30 cycles, got 0 expected 1", name);
  endtask

  // Adaptor model: hold for lat cycles, then complete with random data.
  // Returns at the negedge after completion (the idle cycle).
  task automatic respond(input int lat, input logic [2:0] exp_resp, input string name);
    logic [W-1:0] held;
    logic         stable;
    logic [255:0] line;
    held   = {owner, mem_read, mem_write, mem_addr, mem_wdata};
    stable = 1'b1;
    for (int c = 0; c < lat; c++) begin
      tick();
      if ({owner, mem_read, mem_write, mem_addr, mem_wdata} !== held) stable = 1'b0;
    end
    check({name, " hold"}, W'(stable), W'(1));
    line      = rand_line();
    mem_rdata = line;
    mem_resp  = 1'b1;
    #1;
    check({name, " resp"}, W'({i_resp, d_resp, p_resp}), W'(exp_resp));
    if (exp_resp[2]) check({name, " i_rdata"}, W'(i_rdata), W'(line));
    if (exp_resp[1]) check({name, " d_rdata"}, W'(d_rdata), W'(line));
    if (exp_resp[0]) check({name, " p_rdata"}, W'(p_rdata), W'(line));
    tick();
    mem_resp = 1'b0;
    #1;
    check({name, " idle"}, W'({owner, mem_read, mem_write}), W'(0));
  endtask

  task automatic expect_quiet(input string name);
    logic any;
    any = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      any = any | mem_read | mem_write;
    end
    check(name, W'(any), W'(0));
  endtask

  initial begin
    int exp_cnt;

    vecs[0] = '{1'b1, 32'h0000_1024, 1'b0, 1'b0, 32'h0, '0, 1'b0, 32'h0,
                2'd1, 1'b1, 1'b0, 32'h0000_1020, '0, 3'b100, 6};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000_0047, PAT_A, 1'b0, 32'h0,
                2'd2, 1'b1, 1'b0, 32'h3000_0040, '0, 3'b010, 2};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0044, PAT_B, 1'b0, 32'h0,
                2'd2, 1'b0, 1'b1, 32'h0000_0040, PAT_B, 3'b010, 3};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0, 1'b1, 32'h2000_001f,
                2'd3, 1'b1, 1'b0, 32'h2000_0000, '0, 3'b001, 4};
    vecs[4] = '{1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0100, '0, 1'b1, 32'h0000_0300,
                2'd2, 1'b1, 1'b0, 32'h0000_0100, '0, 3'b010, 2};
    vecs[5] = '{1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0, '0, 1'b1, 32'h0000_0500,
                2'd1, 1'b1, 1'b0, 32'h0000_0400, '0, 3'b100, 3};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, PAT_A, 1'b1, 32'h0000_0600,
                2'd2, 1'b0, 1'b1, 32'hFFFF_FFE0, PAT_A, 3'b010, 1};
    vecs[7] = '{1'b1, 32'h0000_0704, 1'b0, 1'b0, 32'h0, '0, 1'b1, 32'h0000_0700,
                2'd1, 1'b1, 1'b0, 32'h0000_0700, '0, 3'b100, 2};

    // reset
    rst = 1'b1;
    clear_reqs();
    i_addr = '0; d_addr = '0; p_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    tick();
    tick();
    check("reset owner", W'(owner), W'(0));
    check("reset mem ops", W'({mem_read, mem_write}), W'(0));
    check("reset resps", W'({i_resp, d_resp, p_resp}), W'(0));
    check("reset mem_addr", W'(mem_addr), W'(0));
    check("reset mem_wdata", W'(mem_wdata), W'(0));
    check("reset state/starve", W'({dbg_state, dbg_starve_cnt}), W'(0));
    rst = 1'b0;
    tick();

    // vector table
    for (int k = 0; k < NV; k++) begin
      i_read = vecs[k].i_rd; i_addr = vecs[k].i_a;
      d_read = vecs[k].d_rd; d_write = vecs[k].d_wr;
      d_addr = vecs[k].d_a;  d_wdata = vecs[k].d_wd;
      p_read = vecs[k].p_rd; p_addr = vecs[k].p_a;
      sb_push(vecs[k].e_own, vecs[k].e_rd, vecs[k].e_wr, vecs[k].e_addr, vecs[k].e_wd);
      tick();
      sb_pop_check($sformatf("vec%0d issue", k));
      respond(vecs[k].lat, vecs[k].e_resp, $sformatf("vec%0d", k));
      clear_reqs();
    end

    // D write and I read together: D first, one idle cycle, then I
    d_write = 1'b1; d_addr = 32'h0000_0080; d_wdata = PAT_A;
    i_read = 1'b1; i_addr = 32'h0000_1024;
    sb_push(2'd2, 1'b0, 1'b1, 32'h0000_0080, PAT_A);
    sb_push(2'd1, 1'b1, 1'b0, 32'h0000_1020, '0);
    tick();
    sb_pop_check("b2b d write");
    respond(3, 3'b010, "b2b d");
    d_write = 1'b0;
    tick();
    sb_pop_check("b2b i read");
    respond(2, 3'b100, "b2b i");
    clear_reqs();

    // starvation: D and I both held, D wins until the limit, then I
    exp_cnt = 0;
    d_read = 1'b1; d_addr = 32'h0000_00C0;
    i_read = 1'b1; i_addr = 32'h0000_1024;
    for (int g = 0; g < 5; g++) begin
      if (g < 4) begin
        sb_push(2'd2, 1'b1, 1'b0, 32'h0000_00C0, '0);
        exp_cnt = (exp_cnt < 4) ? exp_cnt + 1 : 4;
      end else begin
        sb_push(2'd1, 1'b1, 1'b0, 32'h0000_1020, '0);
        exp_cnt = 0;
      end
      wait_issue($sformatf("starve grant%0d", g));
      sb_pop_check($sformatf("starve grant%0d", g));
      check($sformatf("starve cnt%0d", g), W'(dbg_starve_cnt), W'(exp_cnt));
      respond(1, (g < 4) ? 3'b010 : 3'b100, $sformatf("starve%0d", g));
    end
    clear_reqs();

    // prefetch withdrawn while I is in flight; D takes the next grant
    i_read = 1'b1; i_addr = 32'h0000_1024;
    sb_push(2'd1, 1'b1, 1'b0, 32'h0000_1020, '0);
    tick();
    sb_pop_check("withdraw i issue");
    p_read = 1'b1; p_addr = 32'h0000_3000;
    tick();
    p_read = 1'b0;
    d_read = 1'b1; d_addr = 32'h0000_0140;
    sb_push(2'd2, 1'b1, 1'b0, 32'h0000_0140, '0);
    respond(2, 3'b100, "withdraw i");
    i_read = 1'b0;
    tick();
    sb_pop_check("withdraw d issue");
    respond(2, 3'b010, "withdraw d");
    clear_reqs();
    expect_quiet("withdraw no p issue");

    // prefetch hit by a later i-cache miss to the same line
    p_read = 1'b1; p_addr = 32'h0000_2000;
    sb_push(2'd3, 1'b1, 1'b0, 32'h0000_2000, '0);
    tick();
    sb_pop_check("merge p issue");
    i_read = 1'b1; i_addr = 32'h0000_2000;
    respond(3, 3'b101, "merge");
    clear_reqs();
    expect_quiet("merge single fetch");

    // reset two cycles into an I transaction, then regrant
    i_read = 1'b1; i_addr = 32'h0000_1024;
    sb_push(2'd1, 1'b1, 1'b0, 32'h0000_1020, '0);
    tick();
    sb_pop_check("rst i issue");
    tick();
    rst = 1'b1;
    #1;
    check("rst mid ops", W'({mem_read, mem_write}), W'(0));
    check("rst mid owner", W'(owner), W'(0));
    tick();
    rst = 1'b0;
    sb_push(2'd1, 1'b1, 1'b0, 32'h0000_1020, '0);
    tick();
    sb_pop_check("rst regrant");
    respond(2, 3'b100, "rst regrant");
    clear_reqs();

    check("queue drained", W'(exp_q.size()), W'(0));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Sequences the shared cacheline memory port between the instruction cache, the data cache and the next-line prefetcher. It sits between those three requesters and the cacheline adaptor's cache-side port. It grants one full 256-bit line transaction at a time, registers the request, and holds it stable until the adaptor responds. It enforces data-first priority with a bounded-starvation override for instruction fetch.

## Interface
- STARVE_LIMIT, 4: consecutive d-cache grants taken while i_read is pending before i-cache is forced to win.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_addr  in  32  i-cache line address. i_read  in  1  i-cache read request. i_rdata  out  256  line data. i_resp  out  1  completion pulse.
- d_addr  in  32  d-cache line address. d_read, d_write  in  1 each  request (never both). d_wdata  in  256  writeback line. d_rdata  out  256. d_resp  out  1.
- p_addr  in  32  prefetch line address. p_read  in  1  prefetch request. p_rdata  out  256. p_resp  out  1.
- mem_addr  out  32  to adaptor; bits [4:0] are always 0. mem_read, mem_write  out  1 each. mem_wdata  out  256.
- mem_rdata  in  256  from adaptor. mem_resp  in  1  adaptor completion.
- owner  out  2  current grant: 0 none, 1 I, 2 D, 3 P.

## Operation
- States: IDLE, ISSUE.
- IDLE: arbitrate among the requests valid this cycle. Default priority is D > I > P. If starve_cnt == STARVE_LIMIT and i_read is asserted, I beats D.
- On a grant, latch the owner, op, addr (with [4:0] zeroed) and, for D writes, d_wdata. Go to ISSUE. If no request is valid, stay in IDLE.
- ISSUE: drive mem_read or mem_write, mem_addr and mem_wdata from the latched registers, held constant until mem_resp. On mem_resp:
  - pulse the owner's *_resp for that cycle only;
  - route mem_rdata to the owner's *_rdata;
  - return to IDLE.
- Read-data ports carry mem_rdata at all times. Consumers qualify it with their own *_resp.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - increments, saturating at STARVE_LIMIT, on each D grant made while i_read is asserted;
  - clears on any I grant;
  - is unaffected otherwise.
- I and D must hold their request until their resp. If a requester drops it mid-transaction, the transaction still completes and resp still pulses.
- P may withdraw while not granted. Once granted, the transaction completes normally.
- When the latched P address equals i_addr while i_read is pending, p_resp and i_resp pulse together on completion. The line is not fetched twice.
- mem_read and mem_write are never both high.

## Timing
- Reset values: owner 0; mem_read, mem_write, all *_resp 0; mem_addr, mem_wdata 0; starve_cnt 0; state IDLE. Reset takes effect immediately, including mid-transaction. The adaptor shares rst.
- A request seen in IDLE at cycle N makes mem_read/mem_write high from cycle N+1.
- resp pulses in the same cycle mem_resp is observed.
- The earliest next grant decision is the cycle after resp. Back-to-back transactions therefore have one idle cycle between mem_resp and the next mem_read/mem_write.
- Requests that arrive during ISSUE are not sampled until IDLE.
- If all three requesters assert in the same cycle, D wins unless the starvation override applies.

## Structure
- Add a shared package enum `arb_owner_t` (NONE, I, D, P) and a line-offset constant `LINE_OFFSET_BITS = 5` to rv32i_types.
- One sub-module, `arb_prio_select`: the combinational fixed-priority selector with starvation override. Inputs are the three request bits and the override flag. Output is the owner. Everything else stays in the top module.

## Test plan
- i_read with i_addr=0x0000_1024 alone: mem_read high next cycle with mem_addr=0x0000_1020. mem_resp after 6 cycles gives an i_resp pulse with i_rdata equal to mem_rdata. owner returns to 0.
- d_write and i_read asserted in the same cycle, d_wdata=pattern A: mem_write first with mem_wdata=A. After d_resp there is one idle cycle, then mem_read for I.
- d_read held continuously with i_read held and STARVE_LIMIT=4: four D grants in a row, the fifth grant goes to I, and starve_cnt clears to 0.
- p_read alone, then p_read dropped before grant while d_read rises: D is granted and no P transaction is issued. Separately, P is granted with p_addr=0x2000 and i_read with i_addr=0x2000 arrives: one mem_read, then p_resp and i_resp pulse in the same cycle.
- rst asserted 2 cycles into an ISSUE: mem_read drops in the same cycle and owner goes to 0. After reset releases, a pending i_read is regranted from IDLE.
